rename_2w: RTL

Two-wide register rename stage that supersedes the single-issue renamer. It is parametrised in architectural and physical register count, holds the free list as a circular FIFO, and resolves intra-group dependencies. It keeps a committed map so a flush restores precise state in one cycle, and it registers its outputs behind a valid/ready handshake. It sits between decode and dispatch; retirement feeds it freed registers.

---
 rtl/rename_2w.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rename_2w.sv
// rename_2w: two-wide register rename stage.
//
// Maps architectural registers to physical registers for up to two decoded
// instructions per cycle (lane 0 is older). Free physical registers live in a
// circular FIFO. Dependencies inside a group are resolved by forwarding lane 0's
// new mapping to lane 1. A committed map, updated at retirement, lets a flush
// restore the precise speculative map in a single cycle. Results are registered
// behind a valid/ready handshake.
//
// Optional feature macro: RENAME_X0_PIN_EN
//   defined   - architectural register 0 is hardwired to physical 0. It is never
//               renamed, it never allocates, and its retirements are ignored.
//   undefined - register 0 is an ordinary register.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   in_valid[1:0]            per-lane instruction valid (2'b10 is illegal)
//   in_ready                 group accepted when in_valid != 0 && in_ready
//   in_has_rd[1:0]           lane writes a destination register
//   in_rs1/in_rs2/in_rd      per-lane architectural registers, lane n at [n*AW +: AW]
//   out_valid[1:0]           registered per-lane valid
//   out_ready                dispatch accepts the output group
//   out_phys_rs1/rs2/rd      renamed operands, lane n at [n*PW +: PW]
//   out_old_phys_rd          previous mapping of rd, freed when this op retires
//   out_arch_rd              destination copy for the ROB
//   retire_valid[1:0]        per-lane commit (lane 0 older)
//   retire_arch_rd           committed destination
//   retire_phys_rd           committed new mapping
//   retire_old_phys_rd       register returned to the free list
//   flush                    squash all speculative renames
//   free_count               current free-list occupancy
module rename_2w #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    localparam int AW = $clog2(NUM_ARCH_REGS),
    localparam int PW = $clog2(NUM_PHYS_REGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_has_rd,
    input  logic [2*AW-1:0] in_rs1,
    input  logic [2*AW-1:0] in_rs2,
    input  logic [2*AW-1:0] in_rd,
    output logic [1:0]      out_valid,
    input  logic            out_ready,
    output logic [2*PW-1:0] out_phys_rs1,
    output logic [2*PW-1:0] out_phys_rs2,
    output logic [2*PW-1:0] out_phys_rd,
    output logic [2*PW-1:0] out_old_phys_rd,
    output logic [2*AW-1:0] out_arch_rd,
    input  logic [1:0]      retire_valid,
    input  logic [2*AW-1:0] retire_arch_rd,
    input  logic [2*PW-1:0] retire_phys_rd,
    input  logic [2*PW-1:0] retire_old_phys_rd,
    input  logic            flush,
    output logic [PW:0]     free_count
);

    localparam int NFREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

`ifdef RENAME_X0_PIN_EN
    localparam bit X0_PIN = 1'b1;
`else
    localparam bit X0_PIN = 1'b0;
`endif

    // Architectural state
    logic [PW-1:0] spec_map_q   [NUM_ARCH_REGS];
    logic [PW-1:0] commit_map_q [NUM_ARCH_REGS];
    logic [PW-1:0] commit_map_d [NUM_ARCH_REGS];
    logic [PW-1:0] fifo_q       [NUM_PHYS_REGS];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    // Output register
    logic [1:0]         out_valid_q;
    logic [1:0][PW-1:0] out_prs1_q, out_prs2_q, out_prd_q, out_oprd_q;
    logic [1:0][AW-1:0] out_ard_q;

    // Per-lane views of the packed ports
    logic [1:0][AW-1:0] rs1_l, rs2_l, rd_l, ret_arch_l;
    logic [1:0][PW-1:0] ret_phys_l, ret_old_l;

    assign rs1_l      = in_rs1;
    assign rs2_l      = in_rs2;
    assign rd_l       = in_rd;
    assign ret_arch_l = retire_arch_rd;
    assign ret_phys_l = retire_phys_rd;
    assign ret_old_l  = retire_old_phys_rd;

    logic               accept;
    logic [1:0]         wr, pop, push;
    logic [PW:0]        n_pop, n_push;
    logic [1:0][PW-1:0] alloc, src1, src2, old_rd, new_rd;

    assign in_ready = !flush && (count_q >= (PW+1)'(2)) &&
                      ((out_valid_q == 2'b00) || out_ready);
    assign accept   = (in_valid != 2'b00) && in_ready;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            wr[l]   = in_valid[l] && in_has_rd[l] && !(X0_PIN && (rd_l[l] == '0));
            push[l] = retire_valid[l] && !(X0_PIN && (ret_arch_l[l] == '0));
        end
        pop    = accept ? wr : 2'b00;
        n_pop  = (PW+1)'(pop[0]) + (PW+1)'(pop[1]);
        n_push = (PW+1)'(push[0]) + (PW+1)'(push[1]);
    end

    // Rename lookup; lane 1 takes the entry after lane 0 only if lane 0 popped
    always_comb begin
        alloc[0] = fifo_q[head_q];
        alloc[1] = wr[0] ? fifo_q[head_q + PW'(1)] : fifo_q[head_q];
        for (int l = 0; l < 2; l++) begin
            src1[l]   = (X0_PIN && (rs1_l[l] == '0)) ? '0 : spec_map_q[rs1_l[l]];
            src2[l]   = (X0_PIN && (rs2_l[l] == '0)) ? '0 : spec_map_q[rs2_l[l]];
            old_rd[l] = wr[l] ? spec_map_q[rd_l[l]] : '0;
            new_rd[l] = wr[l] ? alloc[l] : '0;
        end
        // Lane 1 must observe lane 0's mapping, which is not yet in spec_map
        if (wr[0]) begin
            if (rs1_l[1] == rd_l[0]) src1[1] = alloc[0];
            if (rs2_l[1] == rd_l[0]) src2[1] = alloc[0];
            if (wr[1] && (rd_l[1] == rd_l[0])) old_rd[1] = alloc[0];
        end
    end

    // Committed map after this cycle's retirements; lane 1 written last so it wins
    always_comb begin
        commit_map_d = commit_map_q;
        for (int l = 0; l < 2; l++) begin
            if (push[l]) commit_map_d[ret_arch_l[l]] = ret_phys_l[l];
        end
    end

    // On flush every in-flight register is reclaimed: the free registers are
    // exactly the last NFREE entries written before the new tail.
    always_comb begin
        tail_d  = tail_q + n_push[PW-1:0];
        count_d = flush ? (PW+1)'(NFREE) : (count_q - n_pop + n_push);
        head_d  = flush ? (tail_d - PW'(NFREE)) : (head_q + n_pop[PW-1:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= PW'(NFREE);
            count_q <= (PW+1)'(NFREE);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                fifo_q[i] <= (i < NFREE) ? PW'(i + NUM_ARCH_REGS) : '0;
            end
        end else begin
            if (push[0]) fifo_q[tail_q] <= ret_old_l[0];
            if (push[1]) fifo_q[tail_q + PW'(push[0])] <= ret_old_l[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                spec_map_q[i]   <= PW'(i);
                commit_map_q[i] <= PW'(i);
            end
        end else begin
            commit_map_q <= commit_map_d;
            if (flush) begin
                spec_map_q <= commit_map_d;
            end else if (accept) begin
                if (wr[0]) spec_map_q[rd_l[0]] <= alloc[0];
                if (wr[1]) spec_map_q[rd_l[1]] <= alloc[1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= '0;
            out_prs1_q  <= '0;
            out_prs2_q  <= '0;
            out_prd_q   <= '0;
            out_oprd_q  <= '0;
            out_ard_q   <= '0;
        end else if (flush) begin
            out_valid_q <= '0;
        end else if (accept) begin
            out_valid_q <= in_valid;
            out_prs1_q  <= src1;
            out_prs2_q  <= src2;
            out_prd_q   <= new_rd;
            out_oprd_q  <= old_rd;
            out_ard_q   <= rd_l;
        end else if (out_ready) begin
            out_valid_q <= '0;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_phys_rs1    = out_prs1_q;
    assign out_phys_rs2    = out_prs2_q;
    assign out_phys_rd     = out_prd_q;
    assign out_old_phys_rd = out_oprd_q;
    assign out_arch_rd     = out_ard_q;
    assign free_count      = count_q;

endmodule
